// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: MEM-stage load/store bus master.
// Requests the bus for aligned load/store words and runs one bus cycle at a time.
// It raises busy to stall the pipeline while the access is outstanding.
// If the pipeline is stalled when read data arrives, the result is held.
// A bounded wait counter turns a hung slave into a one-cycle bus_err pulse.
module mem_bus_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_en,
  input  logic [1:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        bus_grnt,
  input  logic        bus_rdy,
  input  logic [31:0] bus_rd_data,
  output logic        bus_req,
  output logic [29:0] bus_addr,
  output logic        bus_as,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  output logic [31:0] out,
  output logic        miss_align,
  output logic        busy,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [31:0] hold_data;
  logic        flushed;     // a flush arrived while the bus cycle was in flight

  logic        is_mem;
  logic        aligned;
  logic        start;
  logic        discard;
  logic        timeout;

  // Decode the EX/MEM entry and the per-cycle events that drive the FSM.
  always_comb begin
    is_mem  = ex_en & ((mem_op == 2'b01) | (mem_op == 2'b10));
    aligned = (addr[1:0] == 2'b00);
    start   = (state == IDLE) & is_mem & aligned & ~flush;
    discard = flushed | flush;
    timeout = (state == ACCESS) & ~bus_rdy & ((wait_cnt + 16'd1) == LIMIT);
  end

  assign miss_align = is_mem & ~aligned;

  // Result mux and stall request; busy drops in the same cycle bus_rdy arrives.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    out  = '0;
    busy = 1'b0;
    unique case (state)
      IDLE: begin
        out  = is_mem ? 32'd0 : addr;
        busy = start;
      end
      REQ: begin
        busy = 1'b1;
      end
      ACCESS: begin
        busy = ~bus_rdy;
        if (bus_rdy && bus_rw && !discard) out = bus_rd_data;
      end
      HOLD: begin
        out = hold_data;
      end
      default: ;
    endcase
  end

  // Bus-cycle FSM with registered bus-side outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= IDLE;
      bus_req     <= 1'b0;
      bus_as      <= 1'b0;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      hold_data   <= '0;
      wait_cnt    <= '0;
      bus_err     <= 1'b0;
      flushed     <= 1'b0;
    end else begin
      bus_as  <= 1'b0;
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= REQ;
            bus_req <= 1'b1;
          end
        end
        REQ: begin
          if (flush) begin
            state   <= IDLE;
            bus_req <= 1'b0;
          end else if (bus_grnt) begin
            state       <= ACCESS;
            bus_addr    <= addr[31:2];
            bus_rw      <= (mem_op == 2'b01);
            bus_wr_data <= wr_data;
            bus_as      <= 1'b1;
            wait_cnt    <= '0;
            flushed     <= 1'b0;
          end
        end
        ACCESS: begin
          if (flush) flushed <= 1'b1;
          if (bus_rdy) begin
            bus_req   <= 1'b0;
            hold_data <= bus_rw ? bus_rd_data : 32'd0;
            // A flushed result is dropped, so only a live result waits in HOLD.
            state     <= (stall && !discard) ? HOLD : IDLE;
          end else if (timeout) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (!stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 255: maximum cycles in ACCESS before a bus-timeout error is flagged.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 reset  in  1  reset: synchronous, active-high.
REQ-004 stall  in  1  global pipeline stall, same signal that drives the MEM pipeline register.
REQ-005 flush  in  1  MEM-stage flush.
REQ-006 ex_en  in  1  EX/MEM entry valid.
REQ-007 mem_op  in  2  memory operation: 00 none, 01 load word, 10 store word, 11 reserved (treated as none).
REQ-008 addr  in  32  byte address, or ALU result when mem_op is none.
REQ-009 wr_data  in  32  store data.
REQ-010 bus_grnt  in  1  bus grant from the arbiter.
REQ-011 bus_rdy  in  1  slave ready; accompanies read data.
REQ-012 bus_rd_data  in  32  bus read data.
REQ-013 bus_req  out  1  bus request to the arbiter.
REQ-014 bus_addr  out  30  word address (addr[31:2]).
REQ-015 bus_as  out  1  address strobe.
REQ-016 bus_rw  out  1  1 = read, 0 = write.
REQ-017 bus_wr_data  out  32  write data.
REQ-018 out  out  32  result to the MEM pipeline register.
REQ-019 miss_align  out  1  misaligned access (combinational).
REQ-020 busy  out  1  MEM access in progress; ORed into the global stall by the pipeline controller.
REQ-021 bus_err  out  1  one-cycle pulse on access timeout.

Function
REQ-022 The block SHALL implement the states IDLE, REQ, ACCESS and HOLD.
REQ-023 start = ex_en & (mem_op==01 | mem_op==10) & addr[1:0]==0 & ~flush, evaluated in IDLE; the block SHALL then go to REQ.
REQ-024 miss_align SHALL be 1 when ex_en & mem_op is load/store & addr[1:0]!=0; no bus activity occurs and out=0.
REQ-025 When mem_op is none/reserved or ex_en=0, out SHALL equal addr, busy=0, no bus activity.
REQ-026 In REQ, bus_req=1 and busy=1 hold; on bus_grnt=1 the block SHALL latch addr/rw/wr_data into the bus_* registers, pulse bus_as for exactly one cycle, and enter ACCESS.
REQ-027 In REQ, flush=1 before grant SHALL drop bus_req and return to IDLE next cycle with busy=0.
REQ-028 In ACCESS, bus_req stays 1, bus_addr/bus_rw/bus_wr_data stay stable, and busy=1 until bus_rdy.
REQ-029 On bus_rdy in ACCESS: out = bus_rd_data for a load, 0 for a store, busy=0 in that same cycle, bus_req deasserted next cycle.
REQ-030 If stall=1 in the bus_rdy cycle, the data SHALL be latched and the block enters HOLD, presenting the latched value on out with busy=0 until the first cycle with stall=0, then IDLE.
REQ-031 A flush during ACCESS SHALL NOT abort the bus cycle; busy remains 1 until bus_rdy, the result is discarded and the block returns to IDLE.
REQ-032 A 16-bit wait counter SHALL clear on entry to ACCESS; when it reaches WAIT_LIMIT without bus_rdy, bus_err SHALL pulse, out=0, bus_req drop, and the state return to IDLE.
REQ-033 bus_rdy outside ACCESS SHALL be ignored.
REQ-034 Throughput: back-to-back accesses with grant already held SHALL take 2 cycles minimum (REQ->ACCESS with bus_rdy in the first ACCESS cycle).

Reset
REQ-035 On reset: state=IDLE, bus_req=0, bus_as=0, bus_rw=1, bus_addr=0, bus_wr_data=0, latched data=0, wait counter=0, bus_err=0, busy=0; reset SHALL override any in-progress transaction.

Verification
REQ-036 Load at addr 0x0000_0100, grant in cycle 1, rdy in cycle 3 with data 0xDEAD_BEEF -> bus_addr=0x40, bus_rw=1, one bus_as pulse, busy 1 for 3 cycles, out=0xDEAD_BEEF.
REQ-037 Store at 0x0000_0204, data 0x1234_5678 -> bus_addr=0x81, bus_rw=0, bus_wr_data=0x1234_5678, out=0 on rdy.
REQ-038 Load at 0x0000_0102 -> miss_align=1, bus_req never asserted, busy=0.
REQ-039 Flush in REQ before grant -> bus_req=0 next cycle; flush in ACCESS -> busy held until rdy, state returns to IDLE.
REQ-040 stall=1 in the rdy cycle for 3 cycles -> out holds the read data through HOLD, busy=0, IDLE after stall drops.
REQ-041 WAIT_LIMIT=4, no bus_rdy -> bus_err pulse after 4 ACCESS cycles, busy=0, bus_req=0; reset asserted mid-ACCESS -> all outputs at reset values next cycle.
